// File: rtl/sap1_arith_datapath.sv
// SAP-1 arithmetic slice: accumulator A, B register, add/subtract ALU and
// the bus-side mux that returns A or the ALU result toward the W-bus.
module sap1_arith_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] wbus_in,
  input  logic             nLa,
  input  logic             Ea,
  input  logic             nLb,
  input  logic             Su,
  input  logic             Eu,
  output logic [WIDTH-1:0] a_value,
  output logic [WIDTH-1:0] b_value,
  output logic [WIDTH-1:0] alu_result,
  output logic             carry,
  output logic             zero,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_en,
  output logic             bus_conflict
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [SUM_W-1:0] sum;
  logic [WIDTH-1:0] b_operand;

  // A and B registers; clear wins over any load strobe on the same edge.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      if (!nLa) a_reg <= wbus_in;
      if (!nLb) b_reg <= wbus_in;
    end
  end

  // Subtract is A + ~B + 1, so carry=1 means no borrow.
  always_comb begin
    b_operand = Su ? ~b_reg : b_reg;
    sum       = SUM_W'(a_reg) + SUM_W'(b_operand) + SUM_W'(Su);
  end

  assign a_value      = a_reg;
  assign b_value      = b_reg;
  assign alu_result   = sum[WIDTH-1:0];
  assign carry        = sum[WIDTH];
  assign zero         = ~|sum[WIDTH-1:0];

  // Eu has priority when both enables are asserted.
  always_comb begin
    bus_out = '0;
    if (Eu)      bus_out = sum[WIDTH-1:0];
    else if (Ea) bus_out = a_reg;
  end

  assign bus_en       = Ea | Eu;
  assign bus_conflict = Ea & Eu;

endmodule

// File: tb/tb_sap1_arith_datapath.sv
// Scoreboard bench for sap1_arith_datapath: stimulus pushes expected outputs,
// an independent monitor pops and compares them every cycle.
module tb_sap1_arith_datapath;

  logic       CLK;
  logic       CLR;
  logic [7:0] wbus_in;
  logic       nLa, Ea, nLb, Su, Eu;
  logic [7:0] a_value, b_value, alu_result, bus_out;
  logic       carry, zero, bus_en, bus_conflict;

  sap1_arith_datapath #(.WIDTH(8)) dut (
    .CLK(CLK), .CLR(CLR), .wbus_in(wbus_in),
    .nLa(nLa), .Ea(Ea), .nLb(nLb), .Su(Su), .Eu(Eu),
    .a_value(a_value), .b_value(b_value), .alu_result(alu_result),
    .carry(carry), .zero(zero), .bus_out(bus_out),
    .bus_en(bus_en), .bus_conflict(bus_conflict)
  );

  typedef struct {
    bit         chk;
    int         id;
    logic [7:0] a, b, alu, bus;
    logic       carry, zero, en, conf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   ma, mb;
  int   step_id = 0;
  bit   stim_done = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h expected=%h", name, id, act, exp);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          check("a_value",      e.id, a_value,            e.a);
          check("b_value",      e.id, b_value,            e.b);
          check("alu_result",   e.id, alu_result,         e.alu);
          check("carry",        e.id, 8'(carry),          8'(e.carry));
          check("zero",         e.id, 8'(zero),           8'(e.zero));
          check("bus_out",      e.id, bus_out,            e.bus);
          check("bus_en",       e.id, 8'(bus_en),         8'(e.en));
          check("bus_conflict", e.id, 8'(bus_conflict),   8'(e.conf));
        end
      end
    end
  end

  // Expected ALU value from the current model registers.
  function automatic int model_alu(input int su);
    return su ? ((ma - mb) & 255) : ((ma + mb) & 255);
  endfunction

  // One cycle: drive inputs, push expected outputs, advance the model past the edge.
  task automatic step(input bit clr, input bit nla, input bit nlb, input int w,
                      input bit ea, input bit eu, input bit su, input bit chk);
    exp_t e;
    int   alu;
    @(negedge CLK);
    CLR = clr; nLa = nla; nLb = nlb; wbus_in = 8'(w); Ea = ea; Eu = eu; Su = su;
    alu      = model_alu(su);
    e.chk    = chk;
    e.id     = step_id;
    e.a      = 8'(ma);
    e.b      = 8'(mb);
    e.alu    = 8'(alu);
    e.carry  = su ? (ma >= mb) : ((ma + mb) > 255);
    e.zero   = (alu == 0);
    e.bus    = eu ? 8'(alu) : (ea ? 8'(ma) : 8'h00);
    e.en     = ea | eu;
    e.conf   = ea & eu;
    q.push_back(e);
    step_id++;
    if (clr) begin
      ma = 0; mb = 0;
    end else begin
      if (!nla) ma = w & 255;
      if (!nlb) mb = w & 255;
    end
  endtask

  task automatic load_ab(input int a, input int b);
    step(0, 0, 1, a, 0, 0, 0, 1);
    step(0, 1, 0, b, 0, 0, 0, 1);
  endtask

  initial begin
    int acc;
    ma = 0; mb = 0;
    CLR = 1'b0; nLa = 1'b1; nLb = 1'b1; wbus_in = '0; Ea = 1'b0; Eu = 1'b0; Su = 1'b0;

    // Reset with both strobes active; state before reset is unknown.
    step(1, 0, 0, 8'hAA, 0, 0, 0, 0);
    step(0, 1, 1, 8'h55, 0, 0, 0, 1);

    load_ab(8'h05, 8'h03);
    step(0, 1, 1, 0, 0, 1, 0, 1);       // add -> 08
    step(0, 1, 1, 0, 0, 0, 1, 1);       // sub -> 02 carry 1
    load_ab(8'h02, 8'h05);
    step(0, 1, 1, 0, 0, 1, 1, 1);       // borrow -> FD carry 0
    load_ab(8'hFF, 8'h01);
    step(0, 1, 1, 0, 0, 0, 0, 1);       // wrap -> 00 carry 1 zero 1

    // Accumulate: feed alu_result back into A.
    load_ab(8'h10, 8'h01);
    for (int i = 0; i < 3; i++) begin
      acc = model_alu(0);
      step(0, 0, 1, acc, 0, 1, 0, 1);
    end
    step(0, 1, 1, 0, 1, 0, 0, 1);       // Ea only: A should read 13

    step(0, 1, 1, 0, 1, 1, 0, 1);       // conflict, Eu wins
    step(0, 1, 1, 0, 0, 0, 0, 1);       // bus idle
    step(0, 0, 1, 8'h77, 1, 0, 0, 1);   // load while driving A: old A on bus
    step(0, 0, 0, 8'h3C, 0, 0, 1, 1);   // both load same value
    step(1, 0, 1, 8'h3C, 1, 0, 0, 1);   // clear beats load
    step(0, 1, 1, 0, 1, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom), int'($urandom_range(0, 255)),
           1'($urandom), 1'($urandom), 1'($urandom), 1);
    end
    step(0, 1, 1, 0, 0, 0, 0, 1);
    stim_done = 1;
  end

  // Drain the scoreboard within a bounded number of cycles, then summarise.
  initial begin
    wait (stim_done);
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge CLK);
      #3;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d pending expected=0 pending", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
